fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//   Parametrised instruction-fetch stage that replaces the fixed pcReg/pcAdder/instruction-register path.
//   Owns the PC and issues one read per instruction to the instruction memory, which may have variable latency.
//   Holds the returned word in an IR until the control FSM acknowledges it.
//   Supports branch/jump redirect, squashing of an in-flight fetch, PC wrap-around and a memory timeout.
// PARAMETERS
//   DATA_W    16   instruction / memory data width
//   ADDR_W    10   PC and memory address width
//   PC_STEP   1    PC increment per fetched instruction
//   RESET_PC  0    PC value loaded on reset
//   TIMEOUT   16   max WAIT cycles before a fetch is abandoned (>=2)
// PORTS
//   clk            in   1        clock, all state on rising edge
//   rst            in   1        asynchronous reset, active-high
//   run            in   1        1 = fetching allowed; 0 = no new request issued
//   mem_req        out  1        one-cycle read request strobe
//   mem_addr       out  ADDR_W   read address, valid while mem_req=1 (= pc)
//   mem_rdata      in   DATA_W   read data, sampled when mem_rvalid=1
//   mem_rvalid     in   1        read data valid (one cycle per request)
//   redirect_valid in   1        branch/jump taken this cycle
//   redirect_pc    in   ADDR_W   target PC for redirect
//   ir_ack         in   1        consumer has taken ir_out
//   ir_out         out  DATA_W   instruction register
//   ir_pc          out  ADDR_W   address ir_out was fetched from
//   ir_valid       out  1        ir_out holds an unconsumed instruction
//   pc             out  ADDR_W   address of next fetch
//   fetch_err      out  1        sticky: a fetch timed out
// BEHAVIOUR
//   Reset (async, immediate): state=IDLE, pc=RESET_PC, ir_out=0, ir_pc=0, ir_valid=0, fetch_err=0, squash=0,
//     wait_cnt=0. mem_req=0 throughout reset.
//   mem_req = (state==FETCH) & run & ~redirect_valid (combinational). mem_addr = pc.
//   States:
//   - IDLE:  always go to FETCH on the next edge. This guarantees no request on the first cycle after reset.
//   - FETCH: if redirect_valid, set pc<=redirect_pc and stay in FETCH.
//            else if run, a request is issued: go to WAIT with wait_cnt<=0.
//            else stay in FETCH.
//   - WAIT:  no request. wait_cnt increments each cycle.
//            On mem_rvalid & ~squash & ~redirect_valid: ir_out<=mem_rdata, ir_pc<=pc, ir_valid<=1,
//              pc<=pc+PC_STEP (mod 2^ADDR_W), go to HOLD.
//            On mem_rvalid with squash or redirect_valid: drop the data, clear squash, go to FETCH.
//              If redirect_valid, also pc<=redirect_pc.
//            On redirect_valid without rvalid: pc<=redirect_pc, squash<=1, stay in WAIT.
//            On wait_cnt==TIMEOUT-1 without rvalid: fetch_err<=1, squash<=0, go to FETCH (re-fetch pc).
//              Memory must not answer an abandoned request.
//   - HOLD:  ir_valid=1, no request.
//            On redirect_valid (takes priority over ir_ack): ir_valid<=0, pc<=redirect_pc, go to FETCH.
//            On ir_ack: ir_valid<=0, go to FETCH.
//   mem_rvalid outside WAIT is ignored.
//   Latency: with a 1-cycle memory, a new instruction arrives every 3 cycles if ir_ack is tied high.
//     Request is at cycle n, IR is loaded at n+1 edge, ir_valid is seen at n+2.
//   Width rules: the PC adder is ADDR_W bits and wraps silently; no overflow flag.
//   fetch_err clears only on reset.
// TESTING
//   1. Release rst, run=1, 1-cycle memory, mem[0]=0x1234 -> IDLE for one cycle; mem_req with addr 0 next cycle;
//      ir_out=0x1234, ir_pc=0, ir_valid=1, pc=1.
//   2. Hold ir_ack=0 for 5 cycles in HOLD -> ir_out stable, no mem_req.
//      Then pulse ir_ack -> ir_valid=0; next mem_req has addr 1.
//   3. 3-cycle memory; redirect_pc=0x200 one cycle after the request -> returned word dropped, ir_valid stays 0;
//      next mem_req has addr 0x200.
//   4. redirect_valid and mem_rvalid in the same WAIT cycle (target 0x080) -> data dropped,
//      next mem_req has addr 0x080.
//   5. pc=0x3FF, fetch completes -> ir_pc=0x3FF, pc=0x000.
//   6. TIMEOUT=8, mem_rvalid never arrives -> fetch_err=1 after 8 WAIT cycles; same address re-requested;
//      assert rst mid-WAIT -> all outputs at reset values before the next clock edge.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one read per instruction to a variable-latency
// memory, holds the returned word in the IR until acknowledged, and handles redirect/squash/timeout.
module fetch_unit #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 10,
  parameter int PC_STEP  = 1,
  parameter int RESET_PC = 0,
  parameter int TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              ir_ack,
  output logic [DATA_W-1:0] ir_out,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] RST_PC   = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(PC_STEP);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_HOLD} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [ADDR_W-1:0]   ir_pc_q;
  logic [DATA_W-1:0]   ir_q;
  logic                ir_valid_q;
  logic                err_q;
  logic                squash_q;
  logic [CNT_W-1:0]    wait_cnt_q;
  logic [ADDR_W-1:0]   pc_inc_d;

  // ADDR_W-bit adder: wraps silently past the top of the address space
  assign pc_inc_d = pc_q + STEP;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RST_PC;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
      err_q      <= 1'b0;
      squash_q   <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: state_q <= S_FETCH;
        S_FETCH: begin
          if (redirect_valid) begin
            pc_q <= redirect_pc;
          end else if (run) begin
            state_q    <= S_WAIT;
            wait_cnt_q <= '0;
          end
        end
        S_WAIT: begin
          wait_cnt_q <= wait_cnt_q + CNT_ONE;
          if (mem_rvalid) begin
            if (!squash_q && !redirect_valid) begin
              ir_q       <= mem_rdata;
              ir_pc_q    <= pc_q;
              ir_valid_q <= 1'b1;
              pc_q       <= pc_inc_d;
              state_q    <= S_HOLD;
            end else begin
              squash_q <= 1'b0;
              if (redirect_valid) pc_q <= redirect_pc;
              state_q  <= S_FETCH;
            end
          end else begin
            if (redirect_valid) pc_q <= redirect_pc;
            // Abandoning the request also forgets any pending squash: no reply will come
            if (wait_cnt_q >= CNT_LAST) begin
              err_q    <= 1'b1;
              squash_q <= 1'b0;
              state_q  <= S_FETCH;
            end else if (redirect_valid) begin
              squash_q <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (redirect_valid) begin
            ir_valid_q <= 1'b0;
            pc_q       <= redirect_pc;
            state_q    <= S_FETCH;
          end else if (ir_ack) begin
            ir_valid_q <= 1'b0;
            state_q    <= S_FETCH;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_req   = (state_q == S_FETCH) & run & ~redirect_valid;
  assign mem_addr  = pc_q;
  assign ir_out    = ir_q;
  assign ir_pc     = ir_pc_q;
  assign ir_valid  = ir_valid_q;
  assign pc        = pc_q;
  assign fetch_err = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural variable-latency instruction memory.
module tb_fetch_unit;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              run;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvalid;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              ir_ack;
  logic [DATA_W-1:0] ir_out;
  logic [ADDR_W-1:0] ir_pc;
  logic              ir_valid;
  logic [ADDR_W-1:0] pc;
  logic              fetch_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  int                lat;
  int                mcnt;
  logic [ADDR_W-1:0] maddr;

  fetch_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_STEP(1), .RESET_PC(0), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .run(run),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .ir_ack(ir_ack),
    .ir_out(ir_out), .ir_pc(ir_pc), .ir_valid(ir_valid), .pc(pc), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  // Memory answers `lat` cycles after a request; lat=0 means it never answers
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mcnt  <= 0;
      maddr <= '0;
    end else if (mem_req) begin
      mcnt  <= lat;
      maddr <= mem_addr;
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1;
    end
  end

  assign mem_rvalid = (mcnt == 1);
  assign mem_rdata  = mem[maddr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; ir_ack = 1'b0; lat = 1;
    #2;
    step(); step();
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
    n_tests++; if (pc !== 10'h000) begin n_fail++; $display("FAIL reset_pc got %h exp 000", pc); end
    n_tests++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ir_valid got %b exp 0", ir_valid); end
    n_tests++; if (ir_out !== 16'h0000 || ir_pc !== 10'h000) begin
      n_fail++; $display("FAIL reset_ir got %h/%h exp 0000/000", ir_out, ir_pc); end
    n_tests++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", fetch_err); end
  endtask

  task automatic test_first_fetch();
    rst = 1'b0;
    #1;
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL idle_no_req got %b exp 0", mem_req); end
    step();
    n_tests++; if (mem_req !== 1'b1 || mem_addr !== 10'h000) begin
      n_fail++; $display("FAIL first_req got %b@%h exp 1@000", mem_req, mem_addr); end
    step();
    n_tests++; if (ir_valid !== 1'b0 || mem_req !== 1'b0) begin
      n_fail++; $display("FAIL wait_state got valid=%b req=%b exp 0,0", ir_valid, mem_req); end
    step();
    n_tests++; if (ir_out !== 16'h1234 || ir_pc !== 10'h000 || ir_valid !== 1'b1) begin
      n_fail++; $display("FAIL first_ir got %h@%h v=%b exp 1234@000 v=1", ir_out, ir_pc, ir_valid); end
    n_tests++; if (pc !== 10'h001) begin n_fail++; $display("FAIL first_pc got %h exp 001", pc); end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 5; i++) begin
      step();
      n_tests++; if (ir_out !== 16'h1234 || ir_valid !== 1'b1 || mem_req !== 1'b0) begin
        n_fail++; $display("FAIL hold_%0d got %h v=%b req=%b exp 1234 v=1 req=0", i, ir_out, ir_valid, mem_req); end
    end
    ir_ack = 1'b1;
    step();
    ir_ack = 1'b0;
    n_tests++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL ack_clear got %b exp 0", ir_valid); end
    n_tests++; if (mem_req !== 1'b1 || mem_addr !== 10'h001) begin
      n_fail++; $display("FAIL second_req got %b@%h exp 1@001", mem_req, mem_addr); end
    step(); step();
    n_tests++; if (ir_out !== 16'h1111 || ir_pc !== 10'h001 || pc !== 10'h002) begin
      n_fail++; $display("FAIL second_ir got %h@%h pc=%h exp 1111@001 pc=002", ir_out, ir_pc, pc); end
    ir_ack = 1'b1;
    step();
    ir_ack = 1'b0;
  endtask

  task automatic test_redirect_squash();
    lat = 3;
    n_tests++; if (mem_req !== 1'b1 || mem_addr !== 10'h002) begin
      n_fail++; $display("FAIL sq_req got %b@%h exp 1@002", mem_req, mem_addr); end
    step();
    redirect_valid = 1'b1; redirect_pc = 10'h200;
    step();
    redirect_valid = 1'b0;
    n_tests++; if (pc !== 10'h200) begin n_fail++; $display("FAIL sq_pc got %h exp 200", pc); end
    step();
    n_tests++; if (mem_rvalid !== 1'b1 || ir_valid !== 1'b0) begin
      n_fail++; $display("FAIL sq_rvalid got rv=%b v=%b exp rv=1 v=0", mem_rvalid, ir_valid); end
    step();
    n_tests++; if (ir_valid !== 1'b0 || ir_out !== 16'h1111) begin
      n_fail++; $display("FAIL sq_drop got v=%b ir=%h exp v=0 ir=1111", ir_valid, ir_out); end
    n_tests++; if (mem_req !== 1'b1 || mem_addr !== 10'h200) begin
      n_fail++; $display("FAIL sq_refetch got %b@%h exp 1@200", mem_req, mem_addr); end
  endtask

  task automatic test_redirect_rvalid();
    lat = 1;
    step();
    redirect_valid = 1'b1; redirect_pc = 10'h080;
    n_tests++; if (mem_rvalid !== 1'b1) begin n_fail++; $display("FAIL rr_rvalid got %b exp 1", mem_rvalid); end
    step();
    redirect_valid = 1'b0;
    #1;
    n_tests++; if (ir_valid !== 1'b0 || pc !== 10'h080) begin
      n_fail++; $display("FAIL rr_drop got v=%b pc=%h exp v=0 pc=080", ir_valid, pc); end
    n_tests++; if (mem_req !== 1'b1 || mem_addr !== 10'h080) begin
      n_fail++; $display("FAIL rr_req got %b@%h exp 1@080", mem_req, mem_addr); end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 10'h3FF;
    #1;
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL wrap_req_masked got %b exp 0", mem_req); end
    step();
    redirect_valid = 1'b0;
    #1;
    n_tests++; if (mem_req !== 1'b1 || mem_addr !== 10'h3FF) begin
      n_fail++; $display("FAIL wrap_req got %b@%h exp 1@3ff", mem_req, mem_addr); end
    step(); step();
    n_tests++; if (ir_out !== 16'hA5A5 || ir_pc !== 10'h3FF || ir_valid !== 1'b1) begin
      n_fail++; $display("FAIL wrap_ir got %h@%h v=%b exp a5a5@3ff v=1", ir_out, ir_pc, ir_valid); end
    n_tests++; if (pc !== 10'h000) begin n_fail++; $display("FAIL wrap_pc got %h exp 000", pc); end
    ir_ack = 1'b1;
    step();
    ir_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    int reqs = 0;
    ir_ack = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (mem_req === 1'b1) reqs++;
      step();
    end
    ir_ack = 1'b0;
    n_tests++; if (reqs !== 3) begin n_fail++; $display("FAIL b2b_reqs got %0d exp 3", reqs); end
    n_tests++; if (pc !== 10'h003 || ir_out !== 16'h2222 || ir_pc !== 10'h002) begin
      n_fail++; $display("FAIL b2b_state got pc=%h ir=%h@%h exp 003 2222@002", pc, ir_out, ir_pc); end
  endtask

  task automatic test_timeout();
    lat = 0;
    n_tests++; if (mem_req !== 1'b1 || mem_addr !== 10'h003) begin
      n_fail++; $display("FAIL to_req got %b@%h exp 1@003", mem_req, mem_addr); end
    step();
    for (int i = 0; i < 8; i++) begin
      n_tests++; if (fetch_err !== 1'b0 || mem_req !== 1'b0) begin
        n_fail++; $display("FAIL to_wait_%0d got err=%b req=%b exp 0,0", i, fetch_err, mem_req); end
      step();
    end
    n_tests++; if (fetch_err !== 1'b1) begin n_fail++; $display("FAIL to_err got %b exp 1", fetch_err); end
    n_tests++; if (mem_req !== 1'b1 || mem_addr !== 10'h003) begin
      n_fail++; $display("FAIL to_refetch got %b@%h exp 1@003", mem_req, mem_addr); end
    step(); step(); step();
    n_tests++; if (fetch_err !== 1'b1) begin n_fail++; $display("FAIL to_sticky got %b exp 1", fetch_err); end
    rst = 1'b1;
    #1;
    n_tests++; if (mem_req !== 1'b0 || pc !== 10'h000 || fetch_err !== 1'b0) begin
      n_fail++; $display("FAIL async_rst got req=%b pc=%h err=%b exp 0,000,0", mem_req, pc, fetch_err); end
    n_tests++; if (ir_out !== 16'h0000 || ir_pc !== 10'h000 || ir_valid !== 1'b0) begin
      n_fail++; $display("FAIL async_rst_ir got %h@%h v=%b exp 0000@000 v=0", ir_out, ir_pc, ir_valid); end
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 16'hDEAD;
    mem[10'h000] = 16'h1234;
    mem[10'h001] = 16'h1111;
    mem[10'h002] = 16'h2222;
    mem[10'h080] = 16'h0808;
    mem[10'h200] = 16'hBEEF;
    mem[10'h3FF] = 16'hA5A5;
    test_reset();
    test_first_fetch();
    test_hold();
    test_redirect_squash();
    test_redirect_rvalid();
    test_wrap();
    test_back_to_back();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
